// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM timer.
package pwm_pkg;

  localparam logic PWM_MODE_EDGE   = 1'b0;
  localparam logic PWM_MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  localparam int unsigned PWM_DEF_WIDTH       = 16;
  localparam int unsigned PWM_DEF_CHANNELS    = 4;
  localparam int unsigned PWM_DEF_DEAD_CYCLES = 8;

endpackage

// File: rtl/pwm_deadband.sv
// Complementary output pair with delayed rising edges; pulses shorter than
// DEAD_CYCLES never reach either output.
module pwm_deadband
  import pwm_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = PWM_DEF_DEAD_CYCLES
) (
  input  logic Clk50M,
  input  logic Rst,
  input  logic in_raw,
  output logic out_p,
  output logic out_n
);

  localparam int unsigned CW = (DEAD_CYCLES < 2) ? 1 : $clog2(DEAD_CYCLES);
  localparam logic [CW-1:0] TH = (DEAD_CYCLES == 0) ? '0 : CW'(DEAD_CYCLES - 1);

  logic          r_vld;
  logic          r_lvl;
  logic [CW-1:0] r_cnt;
  logic          w_ok;

  // r_cnt holds how long in_raw has kept its level, saturating at the threshold
  always_ff @(posedge Clk50M) begin
    if (Rst) begin
      r_vld <= 1'b0;
      r_lvl <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_vld <= 1'b1;
      r_lvl <= in_raw;
      if (!r_vld || (in_raw != r_lvl)) begin
        r_cnt <= '0;
      end else if (r_cnt < TH) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    w_ok  = r_vld && ((DEAD_CYCLES == 0) || ((in_raw == r_lvl) && (r_cnt >= TH)));
    out_p = in_raw & w_ok;
    out_n = ~in_raw & w_ok;
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM timer with double-buffered period/duty/mode.
// Optional dead-time pairs are enabled with the PWM_DEADTIME_EN macro.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = PWM_DEF_WIDTH,
  parameter int unsigned CHANNELS = PWM_DEF_CHANNELS
`ifdef PWM_DEADTIME_EN
  ,
  parameter int unsigned DEAD_CYCLES = PWM_DEF_DEAD_CYCLES
`endif
) (
  input  logic                      Clk50M,
  input  logic                      Rst,
  input  logic                      cnt_en,
  input  logic                      mode_in,
  input  logic [WIDTH-1:0]          arr_in,
  input  logic [CHANNELS*WIDTH-1:0] ccr_in,
  input  logic                      load,
  output logic                      pending,
  output logic                      period_tick,
  output logic [CHANNELS-1:0]       o_pwm
`ifdef PWM_DEADTIME_EN
  ,
  output logic [CHANNELS-1:0]       o_pwm_n
`endif
);

  logic [WIDTH-1:0]          r_cnt, r_arr_act, r_arr_pend;
  logic [CHANNELS*WIDTH-1:0] r_ccr_act, r_ccr_pend;
  logic                      r_mode_act, r_mode_pend, r_pending, r_tick;
  pwm_dir_e                  r_dir, w_dir_nxt;
  logic [CHANNELS-1:0]       r_pwm, w_cmp;

  logic                      w_upd, w_mode_eff;
  logic [WIDTH-1:0]          w_arr_eff, w_cnt_nxt;
  logic [CHANNELS*WIDTH-1:0] w_ccr_eff;

  // Values in force this cycle: at an update the incoming set is used at once
  always_comb begin
    w_upd      = cnt_en && (r_cnt == '0);
    w_arr_eff  = r_arr_act;
    w_ccr_eff  = r_ccr_act;
    w_mode_eff = r_mode_act;
    if (w_upd && load) begin
      w_arr_eff  = arr_in;
      w_ccr_eff  = ccr_in;
      w_mode_eff = mode_in;
    end else if (w_upd && r_pending) begin
      w_arr_eff  = r_arr_pend;
      w_ccr_eff  = r_ccr_pend;
      w_mode_eff = r_mode_pend;
    end
  end

  always_comb begin
    w_dir_nxt = r_dir;
    w_cnt_nxt = r_cnt;
    if (!cnt_en) begin
      w_dir_nxt = DIR_UP;
      w_cnt_nxt = '0;
    end else if (w_mode_eff == PWM_MODE_EDGE) begin
      w_dir_nxt = DIR_DOWN;
      w_cnt_nxt = (r_cnt == '0) ? w_arr_eff : r_cnt - WIDTH'(1);
    end else begin
      if (r_cnt == '0) begin
        w_dir_nxt = DIR_UP;
      end else if (r_cnt >= w_arr_eff) begin
        w_dir_nxt = DIR_DOWN;
      end
      if (w_arr_eff == '0) begin
        w_cnt_nxt = '0;
      end else if (w_dir_nxt == DIR_UP) begin
        w_cnt_nxt = r_cnt + WIDTH'(1);
      end else begin
        w_cnt_nxt = r_cnt - WIDTH'(1);
      end
    end
  end

  // Center mode visits 0 once per period, so high time there is 2*ccr-1 cycles
  always_comb begin
    w_cmp = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      w_cmp[i] = cnt_en && (r_cnt < w_ccr_eff[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge Clk50M) begin
    if (Rst) begin
      r_cnt       <= '0;
      r_dir       <= DIR_UP;
      r_arr_act   <= '0;
      r_ccr_act   <= '0;
      r_mode_act  <= PWM_MODE_EDGE;
      r_arr_pend  <= '0;
      r_ccr_pend  <= '0;
      r_mode_pend <= PWM_MODE_EDGE;
      r_pending   <= 1'b0;
      r_tick      <= 1'b0;
      r_pwm       <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_dir  <= w_dir_nxt;
      r_pwm  <= w_cmp;
      r_tick <= w_upd;
      if (load) begin
        r_arr_pend  <= arr_in;
        r_ccr_pend  <= ccr_in;
        r_mode_pend <= mode_in;
      end
      if (w_upd) begin
        r_arr_act  <= w_arr_eff;
        r_ccr_act  <= w_ccr_eff;
        r_mode_act <= w_mode_eff;
        r_pending  <= 1'b0;
      end else begin
        // While idle nothing can tear a pulse, so a pending set goes live now
        if (!cnt_en && r_pending) begin
          r_arr_act  <= r_arr_pend;
          r_ccr_act  <= r_ccr_pend;
          r_mode_act <= r_mode_pend;
        end
        if (load) begin
          r_pending <= 1'b1;
        end else if (!cnt_en) begin
          r_pending <= 1'b0;
        end
      end
    end
  end

  assign pending     = r_pending;
  assign period_tick = r_tick;

`ifdef PWM_DEADTIME_EN
  logic w_db_rst;
  assign w_db_rst = Rst | ~cnt_en;

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_db
    pwm_deadband #(
      .DEAD_CYCLES(DEAD_CYCLES)
    ) u_db (
      .Clk50M(Clk50M),
      .Rst   (w_db_rst),
      .in_raw(r_pwm[g]),
      .out_p (o_pwm[g]),
      .out_n (o_pwm_n[g])
    );
  end
`else
  assign o_pwm = r_pwm;
`endif

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: vector table plus corner sequences.
module tb_pwm_multi_channel;
  import pwm_pkg::*;

  localparam int W  = 16;
  localparam int CH = 4;
`ifdef PWM_DEADTIME_EN
  localparam int DEAD = 3;
`else
  localparam int DEAD = 0;
`endif

  logic            Clk50M = 1'b0;
  logic            Rst, cnt_en, mode_in, load;
  logic [W-1:0]    arr_in;
  logic [CH*W-1:0] ccr_in;
  logic            pending, period_tick;
  logic [CH-1:0]   o_pwm;
`ifdef PWM_DEADTIME_EN
  logic [CH-1:0]   o_pwm_n;
`endif

  always #10 Clk50M = ~Clk50M;

  pwm_multi_channel #(
    .WIDTH   (W),
    .CHANNELS(CH)
`ifdef PWM_DEADTIME_EN
    ,
    .DEAD_CYCLES(DEAD)
`endif
  ) dut (
    .Clk50M     (Clk50M),
    .Rst        (Rst),
    .cnt_en     (cnt_en),
    .mode_in    (mode_in),
    .arr_in     (arr_in),
    .ccr_in     (ccr_in),
    .load       (load),
    .pending    (pending),
    .period_tick(period_tick),
    .o_pwm      (o_pwm)
`ifdef PWM_DEADTIME_EN
    ,
    .o_pwm_n    (o_pwm_n)
`endif
  );

  typedef struct packed {
    logic                mode;
    logic [W-1:0]        arr;
    logic [CH*W-1:0]     ccr;
    logic [7:0]          per;
    logic [CH-1:0][7:0]  hi;
  } vec_t;

  vec_t vecs [6];
  int   checks = 0;
  int   errors = 0;
  int   m_per, m_nn, m_both_low, m_both_hi;
  int   m_hi [CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic m, input int a, input int c0, input int c1,
                              input int c2, input int c3, input int p, input int h0,
                              input int h1, input int h2, input int h3);
    vec_t v;
    v.mode  = m;
    v.arr   = W'(a);
    v.ccr   = {W'(c3), W'(c2), W'(c1), W'(c0)};
    v.per   = 8'(p);
    v.hi[0] = 8'(h0);
    v.hi[1] = 8'(h1);
    v.hi[2] = 8'(h2);
    v.hi[3] = 8'(h3);
    return v;
  endfunction

  // Steady-state high count once rising edges lose DEAD cycles
  function automatic int adj(input int hi, input int per);
    if (DEAD == 0 || hi == 0 || hi == per) return hi;
    return (hi > DEAD) ? hi - DEAD : 0;
  endfunction

  task automatic do_reset();
    @(posedge Clk50M);
    #1;
    Rst = 1'b1; cnt_en = 1'b0; load = 1'b0; mode_in = 1'b0; arr_in = '0; ccr_in = '0;
    repeat (3) @(posedge Clk50M);
    #1 Rst = 1'b0;
  endtask

  task automatic do_load(input logic m, input logic [W-1:0] a, input logic [CH*W-1:0] c);
    @(posedge Clk50M);
    #1;
    load = 1'b1; mode_in = m; arr_in = a; ccr_in = c;
    @(posedge Clk50M);
    #1 load = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge Clk50M);
      n++;
    end while (!period_tick && n < 200);
  endtask

  // Call right after a tick: counts cycles and highs up to the next tick
  task automatic measure();
    m_per = 0; m_nn = 0; m_both_low = 0; m_both_hi = 0;
    for (int i = 0; i < CH; i++) m_hi[i] = 0;
    do begin
      @(negedge Clk50M);
      m_per++;
      for (int i = 0; i < CH; i++) m_hi[i] += int'(o_pwm[i]);
`ifdef PWM_DEADTIME_EN
      m_nn += int'(o_pwm_n[0]);
      if (!o_pwm[0] && !o_pwm_n[0]) m_both_low++;
      if ((o_pwm & o_pwm_n) != '0) m_both_hi++;
`endif
    end while (!period_tick && m_per < 200);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    logic [CH*W-1:0] ccr_a;
    ccr_a = {16'd9, 16'd10, 16'd0, 16'd3};

    vecs[0] = mk(PWM_MODE_EDGE,   9, 3, 0, 10, 9, 10, 3, 0, 10, 9);
    vecs[1] = mk(PWM_MODE_EDGE,   4, 2, 5, 1, 4, 5, 2, 5, 1, 4);
    vecs[2] = mk(PWM_MODE_CENTER, 8, 4, 0, 9, 8, 16, 7, 0, 16, 15);
    vecs[3] = mk(PWM_MODE_CENTER, 1, 1, 2, 0, 1, 2, 1, 2, 0, 1);
    vecs[4] = mk(PWM_MODE_EDGE,   0, 0, 1, 0, 0, 1, 0, 1, 0, 0);
    vecs[5] = mk(PWM_MODE_CENTER, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Reset then idle
    Rst = 1'b1; cnt_en = 1'b0; load = 1'b0; mode_in = 1'b0; arr_in = '0; ccr_in = '0;
    do_reset();
    @(negedge Clk50M);
    chk("rst_pwm", 32'(o_pwm), 0);
    chk("rst_tick", 32'(period_tick), 0);
    chk("rst_pending", 32'(pending), 0);

    for (int k = 0; k < 6; k++) begin
      do_reset();
      do_load(vecs[k].mode, vecs[k].arr, vecs[k].ccr);
      @(negedge Clk50M);
      chk("idle_load_pending", 32'(pending), 1);
      @(negedge Clk50M);
      chk("idle_apply_pending", 32'(pending), 0);
      @(posedge Clk50M);
      #1 cnt_en = 1'b1;
      repeat (8) @(negedge Clk50M);
      wait_tick(n);
      chk("vec_tick_seen", 32'(n < 200), 1);
      measure();
      chk("vec_period", 32'(m_per), 32'(vecs[k].per));
      for (int i = 0; i < CH; i++) begin
        chk("vec_high", 32'(m_hi[i]), 32'(adj(int'(vecs[k].hi[i]), int'(vecs[k].per))));
      end
    end

    // Enable start and double buffering
    do_reset();
    do_load(PWM_MODE_EDGE, 16'd9, ccr_a);
    repeat (2) @(negedge Clk50M);
    @(posedge Clk50M);
    #1 cnt_en = 1'b1;
    @(negedge Clk50M);
    chk("en_first_tick_low", 32'(period_tick), 0);
    @(negedge Clk50M);
    chk("en_first_tick", 32'(period_tick), 1);
    repeat (3) @(posedge Clk50M);
    #1;
    load = 1'b1; arr_in = 16'd4; ccr_in = {16'd9, 16'd10, 16'd0, 16'd2};
    @(posedge Clk50M);
    #1 load = 1'b0;
    @(negedge Clk50M);
    chk("db_pending_set", 32'(pending), 1);
    wait_tick(n);
    chk("db_old_period", 32'(n + 4), 10);
    measure();
    chk("db_new_period", 32'(m_per), 5);
    chk("db_new_ch0", 32'(m_hi[0]), 32'(adj(2, 5)));
    chk("db_new_ch2", 32'(m_hi[2]), 5);
    chk("db_pending_clr", 32'(pending), 0);
    @(posedge Clk50M);
    #1 cnt_en = 1'b0;
    repeat (2) @(negedge Clk50M);
    chk("idle_pwm", 32'(o_pwm), 0);
    chk("idle_tick", 32'(period_tick), 0);

    // arr=0 and load coincident with an update
    do_reset();
    do_load(PWM_MODE_EDGE, 16'd0, '0);
    @(posedge Clk50M);
    #1 cnt_en = 1'b1;
    @(negedge Clk50M);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk50M);
      chk("arr0_tick", 32'(period_tick), 1);
      chk("arr0_pwm", 32'(o_pwm), 0);
    end
    @(posedge Clk50M);
    #1;
    load = 1'b1; arr_in = '0; ccr_in = {16'd0, 16'd0, 16'd0, 16'd1};
    @(posedge Clk50M);
    #1 load = 1'b0;
    @(negedge Clk50M);
    chk("coinc_pending", 32'(pending), 0);
`ifndef PWM_DEADTIME_EN
    chk("coinc_pwm", 32'(o_pwm), 1);
`endif

    // Reset mid-period with a pending set
    do_reset();
    do_load(PWM_MODE_EDGE, 16'd9, ccr_a);
    @(posedge Clk50M);
    #1 cnt_en = 1'b1;
    repeat (15) @(negedge Clk50M);
    chk("run_ch2", 32'(o_pwm[2]), 1);
    @(posedge Clk50M);
    #1;
    load = 1'b1; arr_in = 16'd4;
    @(posedge Clk50M);
    #1 load = 1'b0;
    @(negedge Clk50M);
    chk("mid_pending", 32'(pending), 1);
    @(posedge Clk50M);
    #1 Rst = 1'b1;
    @(posedge Clk50M);
    #1 Rst = 1'b0;
    @(negedge Clk50M);
    chk("mid_rst_pwm", 32'(o_pwm), 0);
    chk("mid_rst_tick", 32'(period_tick), 0);
    chk("mid_rst_pending", 32'(pending), 0);

`ifdef PWM_DEADTIME_EN
    do_reset();
    do_load(PWM_MODE_EDGE, 16'd19, {16'd0, 16'd0, 16'd0, 16'd10});
    @(posedge Clk50M);
    #1 cnt_en = 1'b1;
    repeat (30) @(negedge Clk50M);
    wait_tick(n);
    measure();
    chk("dt_p_high", 32'(m_hi[0]), 7);
    chk("dt_n_high", 32'(m_nn), 7);
    chk("dt_gaps", 32'(m_both_low), 6);
    chk("dt_overlap", 32'(m_both_hi), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
